bsg_bp_mem_channel_splitter: RTL and testbench
==============================================

Name: bsg_bp_mem_channel_splitter

Overview:
- Parametrised N-way BedRock memory command splitter that replaces the fixed 2-way DRAM split in the BlackParrot unicore tile.
- Steers each command from one upstream mem port to one of num_channels_p downstream channels (each a cce-to-mc bridge) by address interleave.
- Returns responses to the upstream port strictly in command order, using a tracker FIFO of channel IDs.
- Bounds total outstanding requests and exposes occupancy and idle status for drain and fence logic.

Parameters:
- num_channels_p, 2, number of downstream channels; power of two, at least 1.
- msg_width_p, 128, width of the flattened BedRock mem message (header plus data); passed through unmodified.
- addr_width_p, 40, width of the command address sideband.
- sel_lsb_p, 6, LSB of the channel-select field in the address (6 gives 64 B block interleave).
- max_outstanding_p, 8, tracker depth; maximum commands issued but not yet responded.
- lg_ch_lp, derived, max(1, $clog2(num_channels_p)).

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  asynchronous, active-high reset.
- cmd_i  in  msg_width_p  upstream command message.
- cmd_addr_i  in  addr_width_p  address of cmd_i, used only for steering.
- cmd_v_i  in  1  upstream command valid.
- cmd_ready_and_o  out  1  upstream command ready.
- resp_o  out  msg_width_p  upstream response message.
- resp_v_o  out  1  upstream response valid.
- resp_ready_and_i  in  1  upstream response ready.
- ch_cmd_o  out  num_channels_p*msg_width_p  per-channel command; every slice carries cmd_i.
- ch_cmd_v_o  out  num_channels_p  per-channel command valid.
- ch_cmd_ready_and_i  in  num_channels_p  per-channel command ready.
- ch_resp_i  in  num_channels_p*msg_width_p  per-channel response.
- ch_resp_v_i  in  num_channels_p  per-channel response valid.
- ch_resp_ready_and_o  out  num_channels_p  per-channel response ready.
- outstanding_o  out  $clog2(max_outstanding_p+1)  current tracker occupancy.
- idle_o  out  1  high when outstanding_o is 0.

Behaviour:
- Handshake: all ports are ready_and. A transfer occurs when v and ready are both high on a rising clk_i.
- Steering: sel = cmd_addr_i[sel_lsb_p +: lg_ch_lp]. When num_channels_p is 1, sel is 0.
- Command issue:
  - ch_cmd_v_o[sel] = cmd_v_i & ~full; all other ch_cmd_v_o bits are 0.
  - cmd_ready_and_o = ch_cmd_ready_and_i[sel] & ~full.
  - Valid toward a channel never depends on that channel's ready.
  - Command path is combinational, 0 cycles added.
- Tracker: a FIFO of max_outstanding_p entries, each lg_ch_lp wide.
  - Push sel on an upstream command handshake.
  - Pop on an upstream response handshake.
  - full = (count == max_outstanding_p); empty = (count == 0).
- Response return:
  - head = tracker head entry.
  - resp_v_o = ~empty & ch_resp_v_i[head].
  - resp_o = ch_resp_i[head].
  - ch_resp_ready_and_o[head] = ~empty & resp_ready_and_i; all other bits are 0.
  - A response valid on a non-head channel is held (backpressured), not dropped or flagged.
  - Response path is combinational, 0 cycles added.
- Simultaneous push and pop:
  - count is unchanged; head and tail both advance.
  - A push is gated on the registered full flag. A pop in the same cycle does not allow a push while full; this costs one bubble cycle at full.
- Pointer wrap: read and write pointers wrap modulo max_outstanding_p. Non-power-of-two depths are legal and wrap at max_outstanding_p-1 back to 0.
- Upstream response when empty: impossible by construction; resp_v_o stays 0. The bench asserts that no channel handshakes a response while the tracker is empty.
- Reset: asynchronous assert clears pointers and count immediately.
  - During reset: cmd_ready_and_o=0, ch_cmd_v_o=0, resp_v_o=0, ch_resp_ready_and_o=0, outstanding_o=0, idle_o=1.
  - Reset mid-operation discards all tracked requests. Downstream channels must be reset in the same domain; late responses after reset are never accepted because the tracker is empty.
- Overflow assertion: outstanding_o never exceeds max_outstanding_p.

Test Plan:
- Defaults, 4 commands with addresses 0x000, 0x040, 0x080, 0x0C0, all channels ready -> issued to channels 0, 1, 0, 1; outstanding_o reaches 4.
- Out-of-order responses: channel 1 responds before channel 0 for the first pair -> ch_resp_ready_and_o[1]=0 until the channel 0 response passes; upstream order is 0, 1, 0, 1.
- num_channels_p=4, max_outstanding_p=3, 3 commands to addr 0x000 with no responses -> 4th command sees cmd_ready_and_o=0. On a response pop the count goes 3->2 and the 4th command is accepted the next cycle.
- Simultaneous push and pop at count=2 -> count stays 2; 20 back-to-back mixed transfers wrap the pointers with order preserved.
- Channel 1 ready held low, command to 0x040 -> ch_cmd_v_o=2'b10, cmd_ready_and_o=0. Raising ready completes the transfer; ch_cmd_v_o[0] stays 0 throughout.
- Assert reset_i asynchronously between clock edges with 5 outstanding -> outputs go to reset values before the next edge; after release idle_o=1 and a new command to 0x040 goes to channel 1.

Source files
------------

// File: rtl/bsg_bp_mem_channel_splitter.sv
// bsg_bp_mem_channel_splitter: steers BedRock mem commands to one of
// num_channels_p channels by address interleave, returns responses in order.
//
// Ports:
//   clk_i, reset_i              clock, async active-high reset
//   cmd_i/cmd_addr_i/cmd_v_i    upstream command, steering address, valid
//   cmd_ready_and_o             upstream command ready
//   resp_o/resp_v_o             upstream response, valid
//   resp_ready_and_i            upstream response ready
//   ch_cmd_o/ch_cmd_v_o         per-channel command (cmd_i copy), valid
//   ch_cmd_ready_and_i          per-channel command ready
//   ch_resp_i/ch_resp_v_i       per-channel response, valid
//   ch_resp_ready_and_o         per-channel response ready
//   outstanding_o, idle_o       tracker occupancy, occupancy == 0
module bsg_bp_mem_channel_splitter
  #(parameter int num_channels_p = 2
   ,parameter int msg_width_p = 128
   ,parameter int addr_width_p = 40
   ,parameter int sel_lsb_p = 6
   ,parameter int max_outstanding_p = 8
   ,localparam int lg_ch_lp =
      (num_channels_p > 1) ? $clog2(num_channels_p) : 1
   ,localparam int cnt_w_lp = $clog2(max_outstanding_p + 1)
   ,localparam int ch_msg_w_lp = num_channels_p * msg_width_p
   )
  (input  logic                      clk_i
  ,input  logic                      reset_i

  ,input  logic [msg_width_p-1:0]    cmd_i
  ,input  logic [addr_width_p-1:0]   cmd_addr_i
  ,input  logic                      cmd_v_i
  ,output logic                      cmd_ready_and_o

  ,output logic [msg_width_p-1:0]    resp_o
  ,output logic                      resp_v_o
  ,input  logic                      resp_ready_and_i

  ,output logic [ch_msg_w_lp-1:0]    ch_cmd_o
  ,output logic [num_channels_p-1:0] ch_cmd_v_o
  ,input  logic [num_channels_p-1:0] ch_cmd_ready_and_i

  ,input  logic [ch_msg_w_lp-1:0]    ch_resp_i
  ,input  logic [num_channels_p-1:0] ch_resp_v_i
  ,output logic [num_channels_p-1:0] ch_resp_ready_and_o

  ,output logic [cnt_w_lp-1:0]       outstanding_o
  ,output logic                      idle_o
  );

  localparam int ptr_w_lp =
    (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  localparam logic [cnt_w_lp-1:0] max_cnt_lp =
    cnt_w_lp'(max_outstanding_p);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp =
    ptr_w_lp'(max_outstanding_p - 1);

  logic [lg_ch_lp-1:0] sel;
  logic [lg_ch_lp-1:0] head;
  logic [lg_ch_lp-1:0] trk_mem [max_outstanding_p];
  logic [ptr_w_lp-1:0] rd_ptr;
  logic [ptr_w_lp-1:0] wr_ptr;
  logic [cnt_w_lp-1:0] count;
  logic full;
  logic empty;
  logic push;
  logic pop;

  // Only the select field steers; the rest of the address is unused here.
  logic unused_addr;
  assign unused_addr = ^cmd_addr_i;

  if (num_channels_p > 1) begin : g_sel
    assign sel = cmd_addr_i[sel_lsb_p +: lg_ch_lp];
  end else begin : g_sel_one
    assign sel = '0;
  end

  function automatic logic [ptr_w_lp-1:0] wrap_inc
    (input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign full  = (count == max_cnt_lp);
  assign empty = (count == '0);
  assign head  = trk_mem[rd_ptr];

  assign ch_cmd_o = {num_channels_p{cmd_i}};

  // Reset gates the command side directly; the response side is
  // already quiet because count clears asynchronously.
  assign cmd_ready_and_o =
    ch_cmd_ready_and_i[sel] & ~full & ~reset_i;

  assign resp_v_o = ~empty & ch_resp_v_i[head];
  assign resp_o   = ch_resp_i[head*msg_width_p +: msg_width_p];

  always_comb begin
    ch_cmd_v_o = '0;
    ch_resp_ready_and_o = '0;
    ch_cmd_v_o[sel] = cmd_v_i & ~full & ~reset_i;
    ch_resp_ready_and_o[head] = ~empty & resp_ready_and_i;
  end

  assign push = cmd_v_i & cmd_ready_and_o;
  assign pop  = resp_v_o & resp_ready_and_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      trk_mem[wr_ptr] <= sel;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   count <= count + cnt_w_lp'(1);
        2'b01:   count <= count - cnt_w_lp'(1);
        default: count <= count;
      endcase
    end
  end

  assign outstanding_o = count;
  assign idle_o        = empty;

endmodule

// File: tb/tb_bsg_bp_mem_channel_splitter.sv
// tb_bsg_bp_mem_channel_splitter: directed vectors and sequences for
// the default 2-channel splitter and a 4-channel, depth-3 instance.
module tb_bsg_bp_mem_channel_splitter;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  // default instance: 2 channels, depth 8
  logic [127:0] cmd_i;
  logic [39:0]  cmd_addr_i;
  logic         cmd_v_i;
  logic         cmd_ready_and_o;
  logic [127:0] resp_o;
  logic         resp_v_o;
  logic         resp_ready_and_i;
  logic [255:0] ch_cmd_o;
  logic [1:0]   ch_cmd_v_o;
  logic [1:0]   ch_cmd_ready_and_i;
  logic [255:0] ch_resp_i;
  logic [1:0]   ch_resp_v_i;
  logic [1:0]   ch_resp_ready_and_o;
  logic [3:0]   outstanding_o;
  logic         idle_o;

  bsg_bp_mem_channel_splitter dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .cmd_i               (cmd_i),
    .cmd_addr_i          (cmd_addr_i),
    .cmd_v_i             (cmd_v_i),
    .cmd_ready_and_o     (cmd_ready_and_o),
    .resp_o              (resp_o),
    .resp_v_o            (resp_v_o),
    .resp_ready_and_i    (resp_ready_and_i),
    .ch_cmd_o            (ch_cmd_o),
    .ch_cmd_v_o          (ch_cmd_v_o),
    .ch_cmd_ready_and_i  (ch_cmd_ready_and_i),
    .ch_resp_i           (ch_resp_i),
    .ch_resp_v_i         (ch_resp_v_i),
    .ch_resp_ready_and_o (ch_resp_ready_and_o),
    .outstanding_o       (outstanding_o),
    .idle_o              (idle_o)
  );

  // second instance: 4 channels, depth 3
  logic [127:0] cmd4;
  logic [39:0]  addr4;
  logic         cmd_v4;
  logic         cmd_rdy4;
  logic [127:0] resp4;
  logic         resp_v4;
  logic         resp_rdy4;
  logic [511:0] ch_cmd4;
  logic [3:0]   ch_cmd_v4;
  logic [3:0]   ch_cmd_rdy4;
  logic [511:0] ch_resp4;
  logic [3:0]   ch_resp_v4;
  logic [3:0]   ch_resp_rdy4;
  logic [1:0]   outst4;
  logic         idle4;

  bsg_bp_mem_channel_splitter #(
    .num_channels_p    (4),
    .max_outstanding_p (3)
  ) dut4 (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .cmd_i               (cmd4),
    .cmd_addr_i          (addr4),
    .cmd_v_i             (cmd_v4),
    .cmd_ready_and_o     (cmd_rdy4),
    .resp_o              (resp4),
    .resp_v_o            (resp_v4),
    .resp_ready_and_i    (resp_rdy4),
    .ch_cmd_o            (ch_cmd4),
    .ch_cmd_v_o          (ch_cmd_v4),
    .ch_cmd_ready_and_i  (ch_cmd_rdy4),
    .ch_resp_i           (ch_resp4),
    .ch_resp_v_i         (ch_resp_v4),
    .ch_resp_ready_and_o (ch_resp_rdy4),
    .outstanding_o       (outst4),
    .idle_o              (idle4)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // channel models: each returns responses to its own commands in order
  logic [127:0] chq0[$];
  logic [127:0] chq1[$];
  logic [127:0] exp_q[$];
  logic [1:0]   ch_hold;

  logic [1:0] last_cmd_v;
  logic       last_push;
  logic       last_resp_v;
  logic [1:0] last_resp_rdy;

  task automatic drive_resp();
    ch_resp_v_i[0] = (chq0.size() != 0) && !ch_hold[0];
    ch_resp_v_i[1] = (chq1.size() != 0) && !ch_hold[1];
    ch_resp_i[127:0]   = (chq0.size() != 0) ? chq0[0] : '0;
    ch_resp_i[255:128] = (chq1.size() != 0) ? chq1[0] : '0;
  endtask

  // one clock: called just after a negedge, returns at the next negedge
  task automatic step();
    logic p, q, c0, c1, r0, r1;
    drive_resp();
    #1;
    p  = cmd_v_i & cmd_ready_and_o;
    q  = resp_v_o & resp_ready_and_i;
    c0 = ch_cmd_v_o[0] & ch_cmd_ready_and_i[0];
    c1 = ch_cmd_v_o[1] & ch_cmd_ready_and_i[1];
    r0 = ch_resp_v_i[0] & ch_resp_ready_and_o[0];
    r1 = ch_resp_v_i[1] & ch_resp_ready_and_o[1];
    last_cmd_v    = ch_cmd_v_o;
    last_push     = p;
    last_resp_v   = resp_v_o;
    last_resp_rdy = ch_resp_ready_and_o;
    if (q) begin
      chk("resp_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("resp_order", resp_o, exp_q.pop_front());
    end
    @(posedge clk_i);
    if (c0) chq0.push_back(cmd_i);
    if (c1) chq1.push_back(cmd_i);
    if (p) exp_q.push_back(cmd_i);
    if (r0) void'(chq0.pop_front());
    if (r1) void'(chq1.pop_front());
    @(negedge clk_i);
  endtask

  task automatic issue(input logic [39:0] a, input logic [127:0] t);
    cmd_addr_i = a;
    cmd_i = t;
    cmd_v_i = 1'b1;
    step();
    cmd_v_i = 1'b0;
  endtask

  task automatic drain();
    cmd_v_i = 1'b0;
    resp_ready_and_i = 1'b1;
    ch_hold = 2'b00;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    chk("drain_left", exp_q.size(), 0);
    chk("drain_idle", idle_o, 1'b1);
    resp_ready_and_i = 1'b0;
  endtask

  // invariants checked every cycle outside reset
  always @(posedge clk_i) begin
    if (!reset_i) begin
      chk("ovf", outstanding_o <= 4'd8, 1'b1);
      chk("ovf4", outst4 <= 2'd3, 1'b1);
      if (outstanding_o == 0)
        chk("empty_hs", |(ch_resp_v_i & ch_resp_ready_and_o), 1'b0);
      if (outst4 == 0)
        chk("empty_hs4", |(ch_resp_v4 & ch_resp_rdy4), 1'b0);
    end
  end

  typedef struct {
    logic [39:0] addr;
    logic        v;
    logic [1:0]  rdy;
    logic [1:0]  exp_chv;
    logic        exp_crdy;
  } vec_t;

  vec_t tv[8];

  initial begin
    int npush;

    tv[0] = '{40'h000, 1'b1, 2'b11, 2'b01, 1'b1};
    tv[1] = '{40'h040, 1'b1, 2'b11, 2'b10, 1'b1};
    tv[2] = '{40'h080, 1'b1, 2'b11, 2'b01, 1'b1};
    tv[3] = '{40'h0C0, 1'b1, 2'b01, 2'b10, 1'b0};
    tv[4] = '{40'h7FC0, 1'b1, 2'b01, 2'b10, 1'b0};
    tv[5] = '{40'h03F, 1'b1, 2'b10, 2'b01, 1'b0};
    tv[6] = '{40'h040, 1'b0, 2'b11, 2'b00, 1'b1};
    tv[7] = '{40'hFF_FFFF_FFBF, 1'b1, 2'b10, 2'b01, 1'b0};

    cmd_i = '0; cmd_addr_i = '0; cmd_v_i = 1'b0;
    resp_ready_and_i = 1'b0; ch_cmd_ready_and_i = 2'b11;
    ch_resp_i = '0; ch_resp_v_i = '0; ch_hold = '0;
    cmd4 = '0; addr4 = '0; cmd_v4 = 1'b0; resp_rdy4 = 1'b0;
    ch_cmd_rdy4 = '0; ch_resp4 = '0; ch_resp_v4 = '0;

    // reset values, with live inputs trying to get through
    reset_i = 1'b1;
    cmd_v_i = 1'b1;
    ch_resp_v_i = 2'b11;
    resp_ready_and_i = 1'b1;
    #1;
    chk("rst_cmd_rdy", cmd_ready_and_o, 1'b0);
    chk("rst_ch_cmd_v", ch_cmd_v_o, 2'b00);
    chk("rst_resp_v", resp_v_o, 1'b0);
    chk("rst_ch_resp_rdy", ch_resp_ready_and_o, 2'b00);
    chk("rst_outst", outstanding_o, 0);
    chk("rst_idle", idle_o, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    cmd_v_i = 1'b0;
    ch_resp_v_i = 2'b00;
    resp_ready_and_i = 1'b0;
    reset_i = 1'b0;
    @(negedge clk_i);

    // combinational steering vectors, withdrawn before each edge
    for (int i = 0; i < 8; i++) begin
      cmd_addr_i = tv[i].addr;
      cmd_v_i = tv[i].v;
      ch_cmd_ready_and_i = tv[i].rdy;
      cmd_i = 128'h55 + 128'(i);
      #1;
      chk("tv_ch_cmd_v", ch_cmd_v_o, tv[i].exp_chv);
      chk("tv_cmd_rdy", cmd_ready_and_o, tv[i].exp_crdy);
      chk("tv_ch_cmd", ch_cmd_o, {cmd_i, cmd_i});
      cmd_v_i = 1'b0;
      @(negedge clk_i);
    end
    chk("tv_outst", outstanding_o, 0);
    ch_cmd_ready_and_i = 2'b11;

    // four interleaved commands
    issue(40'h000, 128'hA0);
    chk("iss0", last_cmd_v, 2'b01);
    issue(40'h040, 128'hA1);
    chk("iss1", last_cmd_v, 2'b10);
    issue(40'h080, 128'hA2);
    chk("iss2", last_cmd_v, 2'b01);
    issue(40'h0C0, 128'hA3);
    chk("iss3", last_cmd_v, 2'b10);
    chk("iss_outst", outstanding_o, 4);

    // channel 1 ready first, must wait behind channel 0
    resp_ready_and_i = 1'b1;
    ch_hold = 2'b01;
    step();
    chk("ooo_resp_v", last_resp_v, 1'b0);
    chk("ooo_rdy_hold", last_resp_rdy, 2'b01);
    ch_hold = 2'b00;
    step();
    chk("ooo_rdy0", last_resp_rdy, 2'b01);
    step();
    chk("ooo_rdy1", last_resp_rdy, 2'b10);
    step();
    chk("ooo_rdy2", last_resp_rdy, 2'b01);
    step();
    chk("ooo_rdy3", last_resp_rdy, 2'b10);
    chk("ooo_idle", idle_o, 1'b1);
    resp_ready_and_i = 1'b0;

    // simultaneous push/pop at count 2, then 20 mixed transfers
    issue(40'h000, 128'h100);
    issue(40'h040, 128'h101);
    chk("sim_outst_pre", outstanding_o, 2);
    resp_ready_and_i = 1'b1;
    issue(40'h080, 128'h102);
    chk("sim_push", last_push, 1'b1);
    chk("sim_outst", outstanding_o, 2);
    npush = 0;
    for (int i = 0; i < 20; i++) begin
      cmd_addr_i = 40'(((i * 5) >> 1) & 1) << 6;
      cmd_i = 128'h200 + 128'(i);
      cmd_v_i = 1'b1;
      step();
      if (last_push) npush++;
    end
    chk("b2b_pushes", npush, 20);
    chk("b2b_outst", outstanding_o, 2);
    drain();

    // channel 1 not ready
    ch_cmd_ready_and_i = 2'b01;
    cmd_addr_i = 40'h040;
    cmd_i = 128'h300;
    cmd_v_i = 1'b1;
    step();
    chk("nrdy_ch_cmd_v", last_cmd_v, 2'b10);
    chk("nrdy_push", last_push, 1'b0);
    step();
    chk("nrdy_ch_cmd_v2", last_cmd_v, 2'b10);
    chk("nrdy_outst", outstanding_o, 0);
    ch_cmd_ready_and_i = 2'b11;
    step();
    chk("nrdy_ch_cmd_v3", last_cmd_v, 2'b10);
    chk("nrdy_push3", last_push, 1'b1);
    cmd_v_i = 1'b0;
    chk("nrdy_outst3", outstanding_o, 1);
    drain();

    // asynchronous reset with 5 outstanding
    for (int i = 0; i < 5; i++)
      issue(40'(i) << 6, 128'h400 + 128'(i));
    chk("ar_outst", outstanding_o, 5);
    cmd_addr_i = 40'h040;
    cmd_v_i = 1'b1;
    resp_ready_and_i = 1'b1;
    drive_resp();
    #1;
    chk("ar_pre_resp_v", resp_v_o, 1'b1);
    #1;
    reset_i = 1'b1;
    #1;
    chk("ar_cmd_rdy", cmd_ready_and_o, 1'b0);
    chk("ar_ch_cmd_v", ch_cmd_v_o, 2'b00);
    chk("ar_resp_v", resp_v_o, 1'b0);
    chk("ar_ch_resp_rdy", ch_resp_ready_and_o, 2'b00);
    chk("ar_outst", outstanding_o, 0);
    chk("ar_idle", idle_o, 1'b1);
    @(negedge clk_i);
    chq0.delete();
    chq1.delete();
    exp_q.delete();
    cmd_v_i = 1'b0;
    resp_ready_and_i = 1'b0;
    drive_resp();
    reset_i = 1'b0;
    #1;
    chk("ar_post_idle", idle_o, 1'b1);
    @(negedge clk_i);
    issue(40'h040, 128'h500);
    chk("ar_new_ch", last_cmd_v, 2'b10);
    chk("ar_new_push", last_push, 1'b1);
    drain();

    // 4 channels, depth 3: full stall, one-bubble recovery, wrap
    ch_cmd_rdy4 = 4'hF;
    addr4 = 40'h000;
    cmd_v4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd4 = 128'hB0 + 128'(i);
      #1;
      chk("d4_ch_cmd_v", ch_cmd_v4, 4'b0001);
      chk("d4_cmd_rdy", cmd_rdy4, 1'b1);
      @(negedge clk_i);
    end
    addr4 = 40'h0C0;
    cmd4 = 128'hB3;
    #1;
    chk("d4_full_outst", outst4, 2'd3);
    chk("d4_full_rdy", cmd_rdy4, 1'b0);
    chk("d4_full_chv", ch_cmd_v4, 4'b0000);
    ch_resp_v4 = 4'b0001;
    ch_resp4[127:0] = 128'hC0;
    resp_rdy4 = 1'b1;
    #1;
    chk("d4_pop_v", resp_v4, 1'b1);
    chk("d4_pop_data", resp4, 128'hC0);
    chk("d4_pop_rdy", cmd_rdy4, 1'b0);
    @(negedge clk_i);
    ch_resp_v4 = 4'b0000;
    #1;
    chk("d4_after_pop", outst4, 2'd2);
    chk("d4_bubble_rdy", cmd_rdy4, 1'b1);
    chk("d4_bubble_chv", ch_cmd_v4, 4'b1000);
    @(negedge clk_i);
    cmd_v4 = 1'b0;
    #1;
    chk("d4_refill", outst4, 2'd3);
    ch_resp_v4 = 4'b1001;
    ch_resp4[127:0] = 128'hC1;
    ch_resp4[511:384] = 128'hC3;
    #1;
    chk("d4_d1_rdy", ch_resp_rdy4, 4'b0001);
    chk("d4_d1_data", resp4, 128'hC1);
    @(negedge clk_i);
    ch_resp4[127:0] = 128'hC2;
    #1;
    chk("d4_d2_rdy", ch_resp_rdy4, 4'b0001);
    chk("d4_d2_data", resp4, 128'hC2);
    @(negedge clk_i);
    ch_resp_v4 = 4'b1000;
    #1;
    chk("d4_d3_rdy", ch_resp_rdy4, 4'b1000);
    chk("d4_d3_data", resp4, 128'hC3);
    @(negedge clk_i);
    ch_resp_v4 = 4'b0000;
    resp_rdy4 = 1'b0;
    #1;
    chk("d4_idle", idle4, 1'b1);

    @(negedge clk_i);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
